// File: rtl/pixel_diffuser_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pixel_diffuser_pkg
// Purpose  : Shared FSM state encoding, key byte geometry and cipher helper
//            for the pixel diffuser.
// Revision : 1.0  initial release
// ============================================================================
package pixel_diffuser_pkg;

  localparam int c_KEY_W         = 8;
  localparam int c_KEYS_PER_WORD = 2;
  localparam int c_KEY_IDX_W     = (c_KEYS_PER_WORD > 1) ? $clog2(c_KEYS_PER_WORD) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Encrypt: (p + k) ^ prev.  Decrypt: (c ^ prev) - k.  All mod 256.
  function automatic logic [c_KEY_W-1:0] cipher_byte(
    input logic               dec,
    input logic [c_KEY_W-1:0] din,
    input logic [c_KEY_W-1:0] key,
    input logic [c_KEY_W-1:0] prev
  );
    if (dec) begin
      return (din ^ prev) - key;
    end
    return (din + key) ^ prev;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_diffuser_if.sv
`default_nettype none
// ============================================================================
// Module   : pixel_diffuser_if
// Purpose  : Keystream, pixel-in and result-out valid/ready streams.
// Revision : 1.0  initial release
// ============================================================================
interface pixel_diffuser_if #(
  parameter int KS_W = 23
);

  logic [KS_W-1:0] ks_data;
  logic            ks_valid;
  logic            ks_ready;
  logic [7:0]      pix_data;
  logic            pix_valid;
  logic            pix_ready;
  logic [7:0]      out_data;
  logic            out_valid;
  logic            out_ready;

  modport master (
    output ks_data, ks_valid, pix_data, pix_valid, out_ready,
    input  ks_ready, pix_ready, out_data, out_valid
  );

  modport slave (
    input  ks_data, ks_valid, pix_data, pix_valid, out_ready,
    output ks_ready, pix_ready, out_data, out_valid
  );

endinterface
`default_nettype wire

// File: rtl/pixel_diffuser_ks_byte_buffer.sv
`default_nettype none
// ============================================================================
// Module   : ks_byte_buffer
// Purpose  : One-word keystream buffer handing out key bytes low byte first;
//            refills in the same cycle its last byte is taken.
// Revision : 1.0  initial release
// ============================================================================
module ks_byte_buffer
  import pixel_diffuser_pkg::*;
#(
  parameter int KS_W = 23
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [KS_W-1:0]    ks_data,
  input  logic               ks_valid,
  output logic               ks_ready,
  output logic [c_KEY_W-1:0] key_byte,
  output logic               key_valid,
  input  logic               key_take
);

  localparam int                     c_WORD_W   = c_KEY_W * c_KEYS_PER_WORD;
  localparam logic [c_KEY_IDX_W-1:0] c_LAST_IDX = c_KEY_IDX_W'(c_KEYS_PER_WORD - 1);

  logic [c_WORD_W-1:0]    r_word;
  logic                   r_full;
  logic [c_KEY_IDX_W-1:0] r_idx;
  logic                   w_take;
  logic                   w_last_take;
  logic                   w_load;

  assign w_take      = key_take && r_full;
  assign w_last_take = w_take && (r_idx == c_LAST_IDX);
  assign ks_ready    = !rst && (!r_full || w_last_take);
  assign w_load      = ks_valid && ks_ready;
  assign key_byte    = r_word[r_idx*c_KEY_W +: c_KEY_W];
  assign key_valid   = r_full;

  // Keystream bits above the used key bytes are dropped.
  generate
    if (KS_W > c_WORD_W) begin : g_ks_upper
      logic w_unused_ks_upper;
      assign w_unused_ks_upper = ^ks_data[KS_W-1:c_WORD_W];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word <= '0;
      r_full <= 1'b0;
      r_idx  <= '0;
    end else if (w_load) begin
      r_word <= ks_data[c_WORD_W-1:0];
      r_full <= 1'b1;
      r_idx  <= '0;
    end else if (w_take) begin
      if (w_last_take) begin
        r_full <= 1'b0;
        r_idx  <= '0;
      end else begin
        r_idx  <= r_idx + c_KEY_IDX_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pixel_diffuser.sv
`default_nettype none
// ============================================================================
// Module   : pixel_diffuser
// Purpose  : Per-frame pixel cipher: keystream byte add plus optional CBC-like
//            chaining, enabled by defining DIFFUSER_FEEDBACK_EN.
// Revision : 1.0  initial release
// ============================================================================
module pixel_diffuser
  import pixel_diffuser_pkg::*;
#(
  parameter int PIX_CNT_W = 20,
  parameter int KS_W      = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 decrypt,
  input  logic [PIX_CNT_W-1:0] num_pixels,
  input  logic [7:0]           iv,
  pixel_diffuser_if.slave      bus,
  output logic                 busy,
  output logic                 done
);

  state_t                 r_state;
  state_t                 w_next;
  logic                   r_decrypt;
  logic [PIX_CNT_W-1:0]   r_num;
  logic [PIX_CNT_W-1:0]   r_count;
  logic [7:0]             r_out_data;
  logic                   r_out_valid;
  logic                   r_done;
  logic [c_KEY_W-1:0]     w_key;
  logic                   w_key_valid;
  logic                   w_pix_ready;
  logic                   w_pix_fire;
  logic                   w_out_fire;
  logic                   w_last;
  logic                   w_start_ok;
  logic [7:0]             w_prev;
  logic [7:0]             w_result;

  ks_byte_buffer #(
    .KS_W (KS_W)
  ) u_ks_buf (
    .clk       (clk),
    .rst       (rst),
    .ks_data   (bus.ks_data),
    .ks_valid  (bus.ks_valid),
    .ks_ready  (bus.ks_ready),
    .key_byte  (w_key),
    .key_valid (w_key_valid),
    .key_take  (w_pix_fire)
  );

  assign w_start_ok  = (r_state == ST_IDLE) && start;
  assign w_pix_ready = (r_state == ST_RUN) && w_key_valid && (!r_out_valid || bus.out_ready);
  assign w_pix_fire  = bus.pix_valid && w_pix_ready;
  assign w_out_fire  = r_out_valid && bus.out_ready;
  assign w_last      = (r_count == r_num - PIX_CNT_W'(1));
  assign w_result    = cipher_byte(r_decrypt, bus.pix_data, w_key, w_prev);

  assign bus.pix_ready = w_pix_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign done          = r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = (num_pixels != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (w_pix_fire && w_last) begin
          w_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (!r_out_valid || bus.out_ready) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_decrypt   <= 1'b0;
      r_num       <= '0;
      r_count     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_decrypt <= decrypt;
        r_num     <= num_pixels;
        r_count   <= '0;
      end
      if (w_pix_fire) begin
        r_count     <= r_count + PIX_CNT_W'(1);
        r_out_data  <= w_result;
        r_out_valid <= 1'b1;
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
      end
      r_done <= (r_state == ST_DONE);
    end
  end

`ifdef DIFFUSER_FEEDBACK_EN
  logic [7:0] r_prev;

  // Decrypt chains on the incoming ciphertext so both directions share prev.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= '0;
    end else if (w_start_ok) begin
      r_prev <= iv;
    end else if (w_pix_fire) begin
      r_prev <= r_decrypt ? bus.pix_data : w_result;
    end
  end

  assign w_prev = r_prev;
`else
  logic w_unused_iv;

  assign w_prev      = '0;
  assign w_unused_iv = ^iv;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pixel_diffuser.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_diffuser
// Purpose  : Directed self-checking bench for pixel_diffuser.
// Revision : 1.0  initial release
// ============================================================================
module tb_pixel_diffuser;

  localparam int PIX_CNT_W = 20;
  localparam int KS_W      = 23;
`ifdef DIFFUSER_FEEDBACK_EN
  localparam bit c_FB = 1'b1;
`else
  localparam bit c_FB = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 decrypt;
  logic [PIX_CNT_W-1:0] num_pixels;
  logic [7:0]           iv;
  logic                 busy;
  logic                 done;

  pixel_diffuser_if #(.KS_W(KS_W)) bus();

  pixel_diffuser #(
    .PIX_CNT_W (PIX_CNT_W),
    .KS_W      (KS_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .decrypt    (decrypt),
    .num_pixels (num_pixels),
    .iv         (iv),
    .bus        (bus),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int              n_tests = 0;
  int              n_fail  = 0;
  logic [KS_W-1:0] ksq[$];
  logic [7:0]      kq[$];
  logic [7:0]      pixq[$];
  logic [7:0]      expq[$];
  logic [7:0]      handq[$];
  logic            f_ks, f_pix, f_out;
  int              fc;
  int              n_out;
  int              stall_lo = -1;
  int              stall_hi = -2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic add_ks(input logic [KS_W-1:0] w);
    ksq.push_back(w);
    kq.push_back(w[7:0]);
    kq.push_back(w[15:8]);
  endtask

  // Reference cipher over the queued pixels, consuming bench-side key bytes.
  task automatic prep(input logic dec, input logic [7:0] ivb);
    logic [7:0] p, k, y, nxt, prev;
    prev = c_FB ? ivb : 8'h00;
    expq.delete();
    foreach (pixq[i]) begin
      p = pixq[i];
      k = (kq.size() > 0) ? kq.pop_front() : 8'h00;
      if (!dec) begin
        y   = 8'(p + k) ^ prev;
        nxt = y;
      end else begin
        y   = 8'((p ^ prev) - k);
        nxt = p;
      end
      if (c_FB) prev = nxt;
      expq.push_back(y);
    end
  endtask

  // One clock: drive at negedge, sample handshakes 1ns later.
  task automatic step(input logic st);
    @(negedge clk);
    start = st;
    if (f_ks) bus.ks_valid = 1'b0;
    if (!bus.ks_valid && ksq.size() > 0) begin
      bus.ks_data  = ksq.pop_front();
      bus.ks_valid = 1'b1;
    end
    if (f_pix) bus.pix_valid = 1'b0;
    if (!bus.pix_valid && pixq.size() > 0) begin
      bus.pix_data  = pixq.pop_front();
      bus.pix_valid = 1'b1;
    end
    bus.out_ready = !(fc >= stall_lo && fc <= stall_hi);
    #1;
    f_ks  = bus.ks_valid && bus.ks_ready;
    f_pix = bus.pix_valid && bus.pix_ready;
    f_out = bus.out_valid && bus.out_ready;
    if (f_out) begin
      n_out++;
      if (expq.size() > 0) check("out_data", {24'h0, bus.out_data}, {24'h0, expq.pop_front()});
    end
    fc++;
  endtask

  task automatic run_frame(input logic dec, input logic [7:0] ivb, input int n,
                           input bit use_hand, input int abort_at);
    logic [7:0] held;
    int         resume;
    int         idx;
    bit         seen;
    decrypt    = dec;
    iv         = ivb;
    num_pixels = PIX_CNT_W'(n);
    prep(dec, ivb);
    if (use_hand) expq = handq;
    n_out  = 0;
    fc     = 0;
    resume = 0;
    seen   = 0;
    held   = 8'h00;
    step(1'b1);
    step(1'b0);
    check("busy_run", {31'h0, busy}, 32'd1);
    for (int c = 0; c < 200 && !seen; c++) begin
      if (abort_at > 0 && fc >= abort_at) return;
      step(1'b0);
      idx = fc - 1;
      if (idx == stall_lo) begin
        held = bus.out_data;
        check("stall_valid", {31'h0, bus.out_valid}, 32'd1);
      end
      if (idx >= stall_lo && idx <= stall_hi) begin
        check("stall_pix_ready", {31'h0, bus.pix_ready}, 32'd0);
        if (idx > stall_lo) check("stall_data", {24'h0, bus.out_data}, {24'h0, held});
      end
      if (stall_lo >= 0 && idx > stall_hi && idx <= stall_hi + 3 && f_out) resume++;
      if (done) seen = 1;
    end
    check("done_seen", {31'h0, seen}, 32'd1);
    check("n_out", n_out, n);
    check("exp_left", expq.size(), 0);
    if (stall_lo >= 0) check("resume_rate", resume, 3);
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    decrypt       = 1'b0;
    num_pixels    = '0;
    iv            = 8'h00;
    bus.ks_data   = '0;
    bus.ks_valid  = 1'b0;
    bus.pix_data  = 8'h00;
    bus.pix_valid = 1'b0;
    bus.out_ready = 1'b0;
    f_ks  = 1'b0;
    f_pix = 1'b0;
    f_out = 1'b0;
    fc    = 0;
    n_out = 0;

    // Reset state, with valids asserted so the readies are meaningful.
    repeat (2) @(negedge clk);
    bus.ks_valid  = 1'b1;
    bus.pix_valid = 1'b1;
    #1;
    check("rst_busy",      {31'h0, busy},          32'd0);
    check("rst_done",      {31'h0, done},          32'd0);
    check("rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
    check("rst_out_data",  {24'h0, bus.out_data},  32'd0);
    check("rst_pix_ready", {31'h0, bus.pix_ready}, 32'd0);
    check("rst_ks_ready",  {31'h0, bus.ks_ready},  32'd0);
    @(negedge clk);
    bus.ks_valid  = 1'b0;
    bus.pix_valid = 1'b0;
    rst           = 1'b0;

    // Golden encrypt vector.
    add_ks(23'h000201);
    pixq = '{8'h10, 8'h20};
    if (c_FB) handq = '{8'hBB, 8'h99};
    else      handq = '{8'h11, 8'h22};
    run_frame(1'b0, 8'hAA, 2, 1'b1, 0);

    // Golden decrypt vector.
    add_ks(23'h000201);
    if (c_FB) pixq = '{8'hBB, 8'h99};
    else      pixq = '{8'h11, 8'h22};
    handq = '{8'h10, 8'h20};
    run_frame(1'b1, 8'hAA, 2, 1'b1, 0);

    // Three pixels leave k1 = 0x06 unused; upper keystream bits must be ignored.
    add_ks(23'h5A0403);
    add_ks(23'h000605);
    pixq = '{8'h01, 8'h02, 8'h03};
    run_frame(1'b0, 8'h00, 3, 1'b0, 0);

    // Empty frame: done two cycles after start, nothing else moves.
    decrypt    = 1'b0;
    num_pixels = '0;
    n_out      = 0;
    step(1'b1);
    step(1'b0);
    check("zero_done_early", {31'h0, done},         32'd0);
    check("zero_busy",       {31'h0, busy},         32'd0);
    check("zero_ks_ready",   {31'h0, bus.ks_ready}, 32'd0);
    step(1'b0);
    check("zero_done",       {31'h0, done},          32'd1);
    check("zero_out_valid",  {31'h0, bus.out_valid}, 32'd0);
    step(1'b0);
    check("zero_done_pulse", {31'h0, done},          32'd0);
    check("zero_n_out",      n_out,                  0);

    // Carried k1 (0x06) keys the first pixel of this frame.
    add_ks(23'h000807);
    pixq = '{8'h01, 8'h09};
    if (c_FB) handq = '{8'h07, 8'h17};
    else      handq = '{8'h07, 8'h10};
    run_frame(1'b0, 8'h00, 2, 1'b1, 0);

    // Five-cycle output stall mid-frame.
    add_ks(23'h001122);
    add_ks(23'h003344);
    add_ks(23'h7F5566);
    add_ks(23'h0077E8);
    pixq = '{8'h00, 8'h11, 8'hF0, 8'h80, 8'h7F, 8'hFF, 8'h42, 8'h99};
    stall_lo = 4;
    stall_hi = 8;
    run_frame(1'b1, 8'h55, 8, 1'b0, 0);
    stall_lo = -1;
    stall_hi = -2;

    // Reset mid-frame with a result pending.
    add_ks(23'h00A1B2);
    add_ks(23'h00C3D4);
    pixq = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_frame(1'b0, 8'h10, 4, 1'b0, 4);
    check("pre_rst_out_valid", {31'h0, bus.out_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
    check("mid_rst_out_data",  {24'h0, bus.out_data},  32'd0);
    check("mid_rst_busy",      {31'h0, busy},          32'd0);
    check("mid_rst_done",      {31'h0, done},          32'd0);
    check("mid_rst_pix_ready", {31'h0, bus.pix_ready}, 32'd0);
    check("mid_rst_ks_ready",  {31'h0, bus.ks_ready},  32'd0);
    bus.ks_valid  = 1'b0;
    bus.pix_valid = 1'b0;
    ksq.delete();
    kq.delete();
    pixq.delete();
    expq.delete();
    f_ks  = 1'b0;
    f_pix = 1'b0;
    f_out = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Fresh frame after reset against the reference model.
    add_ks(23'h12A5C3);
    add_ks(23'h000F0E);
    pixq = '{8'h00, 8'h7F, 8'h80, 8'hFF};
    run_frame(1'b0, 8'h3C, 4, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
